// File: rtl/lcd_cgram_loader_if.sv
// rtl/lcd_cgram_loader_if.sv - pattern-fetch port and LCD pin bundle for the CGRAM loader
interface lcd_cgram_loader_if #(
  parameter int DW = 4
);
  logic          start;
  logic [2:0]    pat_glyph;
  logic [2:0]    pat_row;
  logic [4:0]    pat_data;
  logic          lcd_rs;
  logic          lcd_rw;
  logic          lcd_e;
  logic [DW-1:0] lcd_data;
  logic          busy;
  logic          init_end;

  modport master (
    input  start, pat_data,
    output pat_glyph, pat_row, lcd_rs, lcd_rw, lcd_e, lcd_data, busy, init_end
  );

  modport slave (
    output start, pat_data,
    input  pat_glyph, pat_row, lcd_rs, lcd_rw, lcd_e, lcd_data, busy, init_end
  );
endinterface

// File: rtl/lcd_cgram_loader.sv
// rtl/lcd_cgram_loader.sv - loads NUM_GLYPHS user glyphs into HD44780 CGRAM, then homes DDRAM
module lcd_cgram_loader #(
  parameter int NUM_GLYPHS  = 7,
  parameter int FIRST_GLYPH = 0,
  parameter int BUS_4BIT    = 1,
  parameter int E_PULSE     = 2,
  parameter int GAP_CYCLES  = 3,
  parameter int AUTO_START  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_cgram_loader_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_CMD_ADDR, S_DATA, S_CMD_HOME, S_DONE} state_t;
  typedef enum logic [1:0] {P_SETUP, P_EHIGH, P_HOLD, P_GAP} phase_t;

  localparam logic [15:0] E_LAST = 16'(E_PULSE - 1);
  localparam logic [15:0] G_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [6:0]  NDATA  = 7'(NUM_GLYPHS * 8);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic        nib_q, nib_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic [2:0]  glyph_q, glyph_d;
  logic [2:0]  row_q, row_d;
  logic [6:0]  dcnt_q, dcnt_d;
  logic        auto_q, auto_d;
  logic        byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= P_SETUP;
      cnt_q   <= '0;
      nib_q   <= 1'b0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      glyph_q <= 3'(FIRST_GLYPH);
      row_q   <= '0;
      dcnt_q  <= '0;
      auto_q  <= (AUTO_START != 0);
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      glyph_q <= glyph_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
      auto_q  <= auto_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    nib_d     = nib_q;
    byte_d    = byte_q;
    rs_d      = rs_q;
    glyph_d   = glyph_q;
    row_d     = row_q;
    dcnt_d    = dcnt_q;
    auto_d    = auto_q;
    byte_done = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start || auto_q) begin
          auto_d  = 1'b0;
          state_d = S_CMD_ADDR;
          phase_d = P_SETUP;
          cnt_d   = '0;
          nib_d   = 1'b0;
          byte_d  = {2'b01, 3'(FIRST_GLYPH), 3'b000};
          rs_d    = 1'b0;
          glyph_d = 3'(FIRST_GLYPH);
          row_d   = '0;
          dcnt_d  = '0;
        end
      end
      default: begin
        case (phase_q)
          P_SETUP: begin
            phase_d = P_EHIGH;
            cnt_d   = '0;
          end
          P_EHIGH: begin
            if (cnt_q == E_LAST) phase_d = P_HOLD;
            else                 cnt_d   = cnt_q + 16'd1;
          end
          P_HOLD: begin
            if ((BUS_4BIT != 0) && !nib_q) begin
              nib_d   = 1'b1;
              phase_d = P_SETUP;
            end else if (GAP_CYCLES > 0) begin
              phase_d = P_GAP;
              cnt_d   = '0;
            end else begin
              byte_done = 1'b1;
            end
          end
          default: begin
            if (cnt_q == G_LAST) byte_done = 1'b1;
            else                 cnt_d     = cnt_q + 16'd1;
          end
        endcase
        // The next byte is latched on the edge that opens its SETUP cycle,
        // so pat_data is only sampled here and later changes cannot leak in.
        if (byte_done) begin
          phase_d = P_SETUP;
          nib_d   = 1'b0;
          cnt_d   = '0;
          if (state_q == S_CMD_ADDR || (state_q == S_DATA && dcnt_q != NDATA)) begin
            state_d = S_DATA;
            byte_d  = {3'b000, bus.pat_data};
            rs_d    = 1'b1;
            dcnt_d  = dcnt_q + 7'd1;
            if (row_q == 3'd7) begin
              row_d   = '0;
              glyph_d = glyph_q + 3'd1;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else if (state_q == S_DATA) begin
            state_d = S_CMD_HOME;
            byte_d  = 8'h80;
            rs_d    = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
    endcase
  end

  assign bus.busy      = (state_q == S_CMD_ADDR) || (state_q == S_DATA) || (state_q == S_CMD_HOME);
  assign bus.init_end  = (state_q == S_DONE);
  assign bus.lcd_e     = bus.busy && (phase_q == P_EHIGH);
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.pat_glyph = glyph_q;
  assign bus.pat_row   = row_q;

  generate
    if (BUS_4BIT != 0) begin : g_bus4
      assign bus.lcd_data = nib_q ? byte_q[3:0] : byte_q[7:4];
    end else begin : g_bus8
      assign bus.lcd_data = byte_q;
    end
  endgenerate
endmodule

// File: tb/tb_lcd_cgram_loader.sv
// tb/tb_lcd_cgram_loader.sv - directed self-checking bench for lcd_cgram_loader
module tb_lcd_cgram_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic [4:0] xor_c = '0;

  lcd_cgram_loader_if #(.DW(4)) a_if ();
  lcd_cgram_loader_if #(.DW(8)) b_if ();
  lcd_cgram_loader_if #(.DW(4)) c_if ();

  assign a_if.pat_data = {a_if.pat_glyph[1:0], a_if.pat_row};
  assign b_if.pat_data = {b_if.pat_glyph[1:0], b_if.pat_row};
  assign c_if.pat_data = {c_if.pat_glyph[1:0], c_if.pat_row} ^ xor_c;

  lcd_cgram_loader #(.NUM_GLYPHS(7), .FIRST_GLYPH(0), .BUS_4BIT(1), .E_PULSE(2),
                     .GAP_CYCLES(3), .AUTO_START(1))
    dut_a (.clk(clk), .rst_n(rst_a), .bus(a_if));
  lcd_cgram_loader #(.NUM_GLYPHS(3), .FIRST_GLYPH(5), .BUS_4BIT(0), .E_PULSE(1),
                     .GAP_CYCLES(0), .AUTO_START(1))
    dut_b (.clk(clk), .rst_n(rst_b), .bus(b_if));
  lcd_cgram_loader #(.NUM_GLYPHS(1), .FIRST_GLYPH(0), .BUS_4BIT(1), .E_PULSE(2),
                     .GAP_CYCLES(3), .AUTO_START(0))
    dut_c (.clk(clk), .rst_n(rst_c), .bus(c_if));

  logic [2:0] rst_v, e_v, rs_v, rw_v, busy_v, init_v;
  logic [7:0] dat_v [3];
  logic [2:0] gl_v [3];
  logic [2:0] row_v [3];
  assign rst_v    = {rst_c, rst_b, rst_a};
  assign e_v      = {c_if.lcd_e, b_if.lcd_e, a_if.lcd_e};
  assign rs_v     = {c_if.lcd_rs, b_if.lcd_rs, a_if.lcd_rs};
  assign rw_v     = {c_if.lcd_rw, b_if.lcd_rw, a_if.lcd_rw};
  assign busy_v   = {c_if.busy, b_if.busy, a_if.busy};
  assign init_v   = {c_if.init_end, b_if.init_end, a_if.init_end};
  assign dat_v[0] = {4'h0, a_if.lcd_data};
  assign dat_v[1] = b_if.lcd_data;
  assign dat_v[2] = {4'h0, c_if.lcd_data};
  assign gl_v[0]  = a_if.pat_glyph;
  assign gl_v[1]  = b_if.pat_glyph;
  assign gl_v[2]  = c_if.pat_glyph;
  assign row_v[0] = a_if.pat_row;
  assign row_v[1] = b_if.pat_row;
  assign row_v[2] = c_if.pat_row;

  localparam bit [2:0] IS4 = 3'b101;
  localparam int EW [3] = '{2, 1, 2};
  localparam int FG [3] = '{0, 5, 0};

  // Bus decoder: rebuilds bytes from E rising edges and tracks pulse shape.
  logic [7:0] cap    [3][512];
  bit         cap_rs [3][512];
  int         rise   [3][1024];
  int         nb [3] = '{0, 0, 0};
  int         np [3] = '{0, 0, 0};
  int         wbad [3] = '{0, 0, 0};
  int         rwbad [3] = '{0, 0, 0};
  int         unstable [3] = '{0, 0, 0};
  int         wid [3] = '{0, 0, 0};
  bit         half [3] = '{0, 0, 0};
  bit         eprev [3] = '{0, 0, 0};
  bit   [3:0] hi [3];
  logic [7:0] dstart [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_v[d]) begin
        half[d]  = 1'b0;
        eprev[d] = 1'b0;
        wid[d]   = 0;
      end
      if (e_v[d]) begin
        if (!eprev[d]) begin
          rise[d][np[d]] = cyc;
          np[d]++;
          wid[d]    = 1;
          dstart[d] = dat_v[d];
          if (IS4[d] && !half[d]) begin
            hi[d]   = dat_v[d][3:0];
            half[d] = 1'b1;
          end else begin
            cap[d][nb[d]]    = IS4[d] ? {hi[d], dat_v[d][3:0]} : dat_v[d];
            cap_rs[d][nb[d]] = rs_v[d];
            nb[d]++;
            half[d] = 1'b0;
          end
        end else begin
          wid[d]++;
          if (dat_v[d] !== dstart[d]) unstable[d]++;
        end
      end else if (eprev[d] && wid[d] != EW[d]) begin
        wbad[d]++;
      end
      if (rw_v[d] !== 1'b0) rwbad[d]++;
      eprev[d] = e_v[d];
    end
    xor_c = e_v[2] ? 5'h1f : 5'h00;
  end

  task automatic wait_init(input int d, input int bound, output int ic, output bit ok);
    ok = 1'b0;
    ic = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (init_v[d]) begin
        ok = 1'b1;
        ic = cyc;
        break;
      end
    end
  endtask

  int a_nb0;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({e_v[d], rs_v[d], rw_v[d], busy_v[d], init_v[d], dat_v[d]} !== 13'h0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: got e=%b rs=%b rw=%b busy=%b init=%b data=%h, expected all 0",
                 d, e_v[d], rs_v[d], rw_v[d], busy_v[d], init_v[d], dat_v[d]);
      end
      n_cmp++;
      if (gl_v[d] !== 3'(FG[d]) || row_v[d] !== 3'd0) begin
        n_bad++;
        $display("FAIL reset_pointer dut%0d: got glyph=%0d row=%0d, expected glyph=%0d row=0",
                 d, gl_v[d], row_v[d], FG[d]);
      end
    end
  endtask

  task automatic test_default_load();
    int r, np0, ic;
    bit ok;
    @(negedge clk);
    r = cyc;
    a_nb0 = nb[0];
    np0 = np[0];
    rst_a = 1'b1;
    wait_init(0, 1000, ic, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL default_timeout: init_end got 0, expected 1 within 1000 cycles"); end
    n_cmp++;
    if (nb[0] - a_nb0 != 58) begin n_bad++; $display("FAIL default_bytes: got %0d, expected 58", nb[0] - a_nb0); end
    n_cmp++;
    if (np[0] - np0 != 116) begin n_bad++; $display("FAIL default_pulses: got %0d, expected 116", np[0] - np0); end
    n_cmp++;
    if (cap[0][a_nb0] !== 8'h40 || cap_rs[0][a_nb0] !== 1'b0) begin
      n_bad++; $display("FAIL default_first_cmd: got %h rs=%b, expected 40 rs=0", cap[0][a_nb0], cap_rs[0][a_nb0]);
    end
    n_cmp++;
    if (cap[0][a_nb0+57] !== 8'h80 || cap_rs[0][a_nb0+57] !== 1'b0) begin
      n_bad++; $display("FAIL default_home_cmd: got %h rs=%b, expected 80 rs=0", cap[0][a_nb0+57], cap_rs[0][a_nb0+57]);
    end
    n_cmp++;
    if (rise[0][np0] != r + 2) begin n_bad++; $display("FAIL default_first_e: got cycle %0d, expected %0d", rise[0][np0], r + 2); end
    n_cmp++;
    if (ic - rise[0][np0] != 637) begin n_bad++; $display("FAIL default_init_latency: got %0d, expected 637", ic - rise[0][np0]); end
    n_cmp++;
    if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL default_busy_done: got %b, expected 0", busy_v[0]); end
    n_cmp++;
    if (gl_v[0] !== 3'd7 || row_v[0] !== 3'd0) begin
      n_bad++; $display("FAIL default_final_pointer: got glyph=%0d row=%0d, expected glyph=7 row=0", gl_v[0], row_v[0]);
    end
  endtask

  task automatic test_pattern();
    logic [7:0] exp;
    for (int j = 0; j < 56; j++) begin
      exp = 8'((((j / 8) % 4) << 3) | (j % 8));
      n_cmp++;
      if (cap[0][a_nb0+1+j] !== exp || cap_rs[0][a_nb0+1+j] !== 1'b1) begin
        n_bad++;
        $display("FAIL pattern_byte%0d: got %h rs=%b, expected %h rs=1", j, cap[0][a_nb0+1+j], cap_rs[0][a_nb0+1+j], exp);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    int r, nb0, np0, ic;
    bit ok, hit;
    @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (e_v[0] && rs_v[0]) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL midreset_reach_data: got no data strobe, expected one within 300 cycles"); end
    #2 rst_a = 1'b0;
    #1;
    n_cmp++;
    if ({e_v[0], busy_v[0], init_v[0]} !== 3'b000) begin
      n_bad++; $display("FAIL midreset_async: got e=%b busy=%b init=%b, expected 0 0 0", e_v[0], busy_v[0], init_v[0]);
    end
    repeat (2) @(negedge clk);
    r = cyc;
    nb0 = nb[0];
    np0 = np[0];
    rst_a = 1'b1;
    wait_init(0, 1000, ic, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL midreset_timeout: init_end got 0, expected 1 within 1000 cycles"); end
    n_cmp++;
    if (cap[0][nb0] !== 8'h40 || nb[0] - nb0 != 58) begin
      n_bad++; $display("FAIL midreset_restart: got first=%h bytes=%0d, expected first=40 bytes=58", cap[0][nb0], nb[0] - nb0);
    end
    n_cmp++;
    if (rise[0][np0] != r + 2) begin n_bad++; $display("FAIL midreset_first_e: got cycle %0d, expected %0d", rise[0][np0], r + 2); end
  endtask

  task automatic test_busy_start_and_restart();
    int s, nb0, np0, ic;
    bit ok;
    @(negedge clk);
    s = cyc;
    nb0 = nb[0];
    np0 = np[0];
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    n_cmp++;
    if (init_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      n_bad++; $display("FAIL restart_init_fall: got init=%b busy=%b, expected init=0 busy=1", init_v[0], busy_v[0]);
    end
    repeat (40) @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    repeat (200) @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_init(0, 1000, ic, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL restart_timeout: init_end got 0, expected 1 within 1000 cycles"); end
    n_cmp++;
    if (nb[0] - nb0 != 58 || np[0] - np0 != 116) begin
      n_bad++; $display("FAIL restart_counts: got bytes=%0d pulses=%0d, expected 58 116", nb[0] - nb0, np[0] - np0);
    end
    n_cmp++;
    if (ic != s + 639) begin n_bad++; $display("FAIL restart_init_cycle: got %0d, expected %0d", ic, s + 639); end
    n_cmp++;
    if (cap[0][nb0] !== 8'h40) begin n_bad++; $display("FAIL restart_first_cmd: got %h, expected 40", cap[0][nb0]); end
  endtask

  task automatic test_8bit();
    int r, nb0, np0, ic;
    bit ok;
    logic [7:0] exp;
    @(negedge clk);
    r = cyc;
    nb0 = nb[1];
    np0 = np[1];
    rst_b = 1'b1;
    wait_init(1, 300, ic, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL b8_timeout: init_end got 0, expected 1 within 300 cycles"); end
    n_cmp++;
    if (nb[1] - nb0 != 26 || np[1] - np0 != 26) begin
      n_bad++; $display("FAIL b8_counts: got bytes=%0d pulses=%0d, expected 26 26", nb[1] - nb0, np[1] - np0);
    end
    n_cmp++;
    if (cap[1][nb0] !== 8'h68 || cap_rs[1][nb0] !== 1'b0) begin
      n_bad++; $display("FAIL b8_first_cmd: got %h rs=%b, expected 68 rs=0", cap[1][nb0], cap_rs[1][nb0]);
    end
    for (int j = 0; j < 24; j++) begin
      exp = 8'((((5 + j / 8) % 4) << 3) | (j % 8));
      n_cmp++;
      if (cap[1][nb0+1+j] !== exp || cap_rs[1][nb0+1+j] !== 1'b1) begin
        n_bad++; $display("FAIL b8_data%0d: got %h rs=%b, expected %h rs=1", j, cap[1][nb0+1+j], cap_rs[1][nb0+1+j], exp);
      end
    end
    n_cmp++;
    if (cap[1][nb0+25] !== 8'h80 || cap_rs[1][nb0+25] !== 1'b0) begin
      n_bad++; $display("FAIL b8_home_cmd: got %h rs=%b, expected 80 rs=0", cap[1][nb0+25], cap_rs[1][nb0+25]);
    end
    n_cmp++;
    if (rise[1][np0] != r + 2) begin n_bad++; $display("FAIL b8_first_e: got cycle %0d, expected %0d", rise[1][np0], r + 2); end
    n_cmp++;
    if (ic - rise[1][np0] != 77) begin n_bad++; $display("FAIL b8_init_latency: got %0d, expected 77", ic - rise[1][np0]); end
  endtask

  task automatic test_auto_start_off();
    int s, nb0, np0, ic;
    bit ok;
    logic [7:0] exp;
    @(negedge clk);
    rst_c = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({e_v[2], rs_v[2], busy_v[2], init_v[2], dat_v[2]} !== 12'h0) begin
      n_bad++; $display("FAIL noauto_idle: got e=%b rs=%b busy=%b init=%b data=%h, expected all 0",
                        e_v[2], rs_v[2], busy_v[2], init_v[2], dat_v[2]);
    end
    s = cyc;
    nb0 = nb[2];
    np0 = np[2];
    c_if.start = 1'b1;
    @(negedge clk);
    c_if.start = 1'b0;
    wait_init(2, 400, ic, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL noauto_timeout: init_end got 0, expected 1 within 400 cycles"); end
    n_cmp++;
    if (nb[2] - nb0 != 10 || np[2] - np0 != 20) begin
      n_bad++; $display("FAIL noauto_counts: got bytes=%0d pulses=%0d, expected 10 20", nb[2] - nb0, np[2] - np0);
    end
    for (int j = 0; j < 10; j++) begin
      exp = (j == 0) ? 8'h40 : (j == 9) ? 8'h80 : 8'(j - 1);
      n_cmp++;
      if (cap[2][nb0+j] !== exp) begin
        n_bad++; $display("FAIL noauto_byte%0d: got %h, expected %h", j, cap[2][nb0+j], exp);
      end
    end
    n_cmp++;
    if (ic != s + 111) begin n_bad++; $display("FAIL noauto_init_cycle: got %0d, expected %0d", ic, s + 111); end
  endtask

  task automatic test_protocol();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (wbad[d] != 0) begin n_bad++; $display("FAIL e_width dut%0d: got %0d bad pulses, expected 0", d, wbad[d]); end
      n_cmp++;
      if (rwbad[d] != 0) begin n_bad++; $display("FAIL rw_low dut%0d: got %0d cycles with rw!=0, expected 0", d, rwbad[d]); end
      n_cmp++;
      if (unstable[d] != 0) begin n_bad++; $display("FAIL data_stable dut%0d: got %0d changes during E, expected 0", d, unstable[d]); end
    end
  endtask

  initial begin
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    c_if.start = 1'b0;
    test_reset();
    test_default_load();
    test_pattern();
    test_reset_mid_data();
    test_busy_start_and_restart();
    test_8bit();
    test_auto_start_off();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_cgram_loader.md
Name: lcd_cgram_loader

Overview:
- Parametrised successor to the fixed-pattern CGRAM initialiser for the HD44780-class character LCD.
- Writes NUM_GLYPHS user glyphs (5x8, 8 rows each) into CGRAM. Row bitmaps are fetched from an external pattern source through a glyph/row lookup port, so no bitmaps are hard-wired.
- Supports 4-bit or 8-bit bus mode, programmable E timing and inter-byte gap, start/restart handshake, and a trailing DDRAM-home command.
- Sits between reset/game-control logic and the LCD pin mux. While init_end=1 the mux hands the bus to the display writer.

Parameters:
- NUM_GLYPHS, 7, glyphs to load (1..8).
- FIRST_GLYPH, 0, first CGRAM slot. Constraint: FIRST_GLYPH+NUM_GLYPHS <= 8.
- BUS_4BIT, 1, 1 = 4-bit bus (high nibble first); 0 = 8-bit bus.
- E_PULSE, 2, clk cycles E is held high per bus write (>=1).
- GAP_CYCLES, 3, idle clk cycles after each complete byte, for LCD execution time (>=0).
- AUTO_START, 1, 1 = begin a load automatically on the first cycle after reset release.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle request to (re)load CGRAM.
- pat_glyph, out, 3, glyph index (absolute CGRAM slot) being fetched.
- pat_row, out, 3, row index 0..7 being fetched.
- pat_data, in, 5, row bitmap for pat_glyph/pat_row. Combinational, valid in the same cycle.
- lcd_rs, out, 1, register select (0 = command, 1 = data).
- lcd_rw, out, 1, read/write select. Tied 0.
- lcd_e, out, 1, enable strobe.
- lcd_data, out, BUS_4BIT?4:8, LCD data bus.
- busy, out, 1, load in progress.
- init_end, out, 1, load complete. Held until the next start.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, pat_glyph=FIRST_GLYPH, pat_row=0. Top FSM = IDLE. A load in progress is abandoned immediately, with no partial strobe and E forced low.
- Top FSM states: IDLE, CMD_ADDR, DATA, CMD_HOME, DONE.
  - IDLE -> CMD_ADDR on start=1, or on the first cycle after reset release if AUTO_START=1.
  - CMD_ADDR: sends one command byte 0x40 | (FIRST_GLYPH<<3), rs=0. CGRAM then auto-increments.
  - DATA: sends NUM_GLYPHS*8 bytes {3'b000, pat_data}, rs=1. Row order is 0..7 for glyph FIRST_GLYPH, then the next glyph. pat_row wraps 7->0 and increments pat_glyph.
  - CMD_HOME: sends one command byte 0x80 (DDRAM address 0), rs=0.
  - DONE: init_end=1, busy=0. start=1 in DONE -> clears init_end next cycle and enters CMD_ADDR (restart).
- busy=1 in CMD_ADDR, DATA and CMD_HOME. start while busy=1 is ignored.
- Byte latching: the byte value and rs are latched on the first SETUP cycle of the byte. pat_glyph/pat_row are stable during the cycle before that latch. pat_data changes mid-byte have no effect.
- Bus-write sub-sequence, one nibble or byte:
  - SETUP: 1 cycle, E=0, rs/data valid.
  - E_HIGH: E_PULSE cycles, E=1, rs/data stable.
  - HOLD: 1 cycle, E=0, rs/data stable.
- Byte sequence:
  - 4-bit mode: nibble write data[7:4], then nibble write data[3:0], then GAP for GAP_CYCLES cycles (E=0, data holds last value).
  - 8-bit mode: one write, then GAP.
- Cycles per byte: 4-bit = 2*(E_PULSE+2)+GAP_CYCLES; 8-bit = E_PULSE+2+GAP_CYCLES.
- Total bytes = NUM_GLYPHS*8+2.
- Latency:
  - First SETUP cycle begins one clk after start is sampled, or one clk after reset release when AUTO_START=1.
  - init_end rises exactly (total bytes)*(cycles per byte) cycles after the first SETUP cycle.
- lcd_rw is 0 at all times. lcd_e never rises outside E_HIGH.
- Edge cases:
  - start coincident with rst_n release: reset wins; the AUTO_START rule applies.
  - GAP_CYCLES=0: the next SETUP follows HOLD directly.
  - NUM_GLYPHS=1: exactly 8 data bytes.

Test Plan:
- Defaults (4-bit, E_PULSE=2, GAP=3, 7 glyphs), AUTO_START -> 58 bytes and 116 E pulses. First two nibbles are 4,0 with rs=0; last two are 8,0 with rs=0. init_end rises 638 cycles after the first SETUP cycle.
- Pattern source returns {glyph[1:0], row} -> each data byte = {3'b000, pat_data}. Glyph order runs 0..6, rows 0..7. pat_row wraps 7->0 and pat_glyph increments at each wrap.
- BUS_4BIT=0, FIRST_GLYPH=5, NUM_GLYPHS=3, E_PULSE=1, GAP=0 -> first byte 0x68 rs=0, then 24 data bytes, then 0x80. 26 E pulses of 1 cycle each, init_end at 26*3=78 cycles.
- Assert rst_n low mid-DATA (during E_HIGH) -> lcd_e, busy and init_end go 0 asynchronously. After release with AUTO_START=1, the sequence restarts with 0x40.
- start pulses while busy -> ignored, byte count unchanged. start in DONE -> init_end falls next cycle and a full reload of 58 bytes follows.
- AUTO_START=0 -> bus idle (all 0) until start. Changing pat_data during E_HIGH does not alter lcd_data.
